// File: rtl/umul_seq_ctrl_pkg.sv
// Shared definitions for the uMUL sequencer: FSM state encoding and default window sizing.
package umul_seq_ctrl_pkg;

  localparam int DEF_BITWIDTH = 8;
  localparam int WINDOW       = 1 << DEF_BITWIDTH;

  // ST_CLR is a one-cycle abort state that pulses the RNG clear before returning to IDLE
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_DONE = 3'd3,
    ST_CLR  = 3'd4
  } state_t;

endpackage

// File: rtl/umul_seq_ctrl.sv
// Sequencer for one repeated-B sobol uMUL lane: loads B, streams A as a unary window of
// 2^BITWIDTH cycles, popcounts the product stream and returns it over valid/ready.
module umul_seq_ctrl
  import umul_seq_ctrl_pkg::*;
#(
  parameter int BITWIDTH = DEF_BITWIDTH
) (
  input  logic                iClk,
  input  logic                iRstN,
  input  logic                iValid,
  output logic                oReady,
  input  logic [BITWIDTH-1:0] iA,
  input  logic [BITWIDTH-1:0] iB,
  input  logic                iAbort,
  output logic                oLoadB,
  output logic [BITWIDTH-1:0] oBVal,
  output logic                oClr,
  output logic                oA,
  input  logic                iMult,
  output logic                oValid,
  input  logic                iReady,
  output logic [BITWIDTH-1:0] oResult,
  output logic                oBusy
);

  state_t              state;
  state_t              state_next;
  logic [BITWIDTH-1:0] a_reg;
  logic [BITWIDTH-1:0] b_reg;
  logic [BITWIDTH-1:0] cnt;
  logic [BITWIDTH-1:0] acc;
  logic                accept;

  assign accept = iValid && (state == ST_IDLE);
  assign oBVal  = b_reg;

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // acc cannot overflow: at most A_reg ones are returned, and A_reg fits in BITWIDTH bits
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      a_reg <= '0;
      b_reg <= '0;
      cnt   <= '0;
      acc   <= '0;
    end else begin
      if (accept) begin
        a_reg <= iA;
        b_reg <= iB;
      end
      if (state == ST_LOAD) begin
        cnt <= '0;
        acc <= '0;
      end else if (state == ST_RUN) begin
        cnt <= cnt + 1'b1;
        acc <= acc + {{(BITWIDTH-1){1'b0}}, iMult};
      end
    end
  end

  always_comb begin
    state_next = state;
    oReady     = 1'b0;
    oLoadB     = 1'b0;
    oClr       = 1'b0;
    oA         = 1'b0;
    oValid     = 1'b0;
    oBusy      = 1'b0;
    oResult    = '0;
    unique case (state)
      ST_IDLE: begin
        oReady = 1'b1;
        if (iValid) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        oLoadB     = 1'b1;
        oClr       = 1'b1;
        oBusy      = 1'b1;
        state_next = iAbort ? ST_CLR : ST_RUN;
      end
      // abort takes priority over the final window cycle and silences oA immediately
      ST_RUN: begin
        oBusy = 1'b1;
        if (iAbort) begin
          state_next = ST_CLR;
        end else begin
          oA = (cnt < a_reg);
          if (cnt == {BITWIDTH{1'b1}}) state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        oBusy   = 1'b1;
        oValid  = 1'b1;
        oResult = acc;
        if (iReady) state_next = ST_IDLE;
      end
      ST_CLR: begin
        oClr       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_umul_seq_ctrl.sv
// Bench for umul_seq_ctrl wired to a behavioural sobol uMUL; expected counts come from a
// golden popcount function and are queued per job, then popped when the result handshakes.
module tb_umul_seq_ctrl;
  import umul_seq_ctrl_pkg::*;

  localparam int BW = DEF_BITWIDTH;

  logic          iClk;
  logic          iRstN;
  logic          iValid;
  logic          oReady;
  logic [BW-1:0] iA;
  logic [BW-1:0] iB;
  logic          iAbort;
  logic          oLoadB;
  logic [BW-1:0] oBVal;
  logic          oClr;
  logic          oA;
  logic          iMult;
  logic          oValid;
  logic          iReady;
  logic [BW-1:0] oResult;
  logic          oBusy;

  int errors = 0;
  int checks = 0;
  int sb[$];
  int aOnes;

  logic [BW-1:0] mulB;
  logic [BW-1:0] mulIdx;

  umul_seq_ctrl #(.BITWIDTH(BW)) dut (
    .iClk(iClk), .iRstN(iRstN), .iValid(iValid), .oReady(oReady),
    .iA(iA), .iB(iB), .iAbort(iAbort), .oLoadB(oLoadB), .oBVal(oBVal),
    .oClr(oClr), .oA(oA), .iMult(iMult), .oValid(oValid), .iReady(iReady),
    .oResult(oResult), .oBusy(oBusy)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  function automatic logic [BW-1:0] bitRev(input logic [BW-1:0] v);
    logic [BW-1:0] r;
    for (int i = 0; i < BW; i++) r[i] = v[BW-1-i];
    return r;
  endfunction

  // golden count: the first a sobol points gated by B > point
  function automatic int golden(input int a, input int b);
    int n = 0;
    logic [BW-1:0] idx;
    for (int i = 0; i < a; i++) begin
      idx = BW'(i);
      if (b > int'(bitRev(idx))) n++;
    end
    return n;
  endfunction

  // uMUL model: RNG index advances only on A ones
  always @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      mulB   <= '0;
      mulIdx <= '0;
    end else begin
      if (oLoadB) mulB <= oBVal;
      if (oClr) mulIdx <= '0;
      else if (oA) mulIdx <= mulIdx + 1'b1;
    end
  end
  assign iMult = oA & (mulB > bitRev(mulIdx));

  always @(posedge iClk) begin
    if (oLoadB) aOnes <= 0;
    else if (oA) aOnes <= aOnes + 1;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int a, input int b, input bit keep);
    checkOutput("ready_before_accept", 32'(oReady), 32'd1);
    iValid = 1'b1;
    iA     = BW'(a);
    iB     = BW'(b);
    @(posedge iClk); #1;
    iValid = 1'b0;
    checkOutput("load_strobes", 32'({oLoadB, oClr, oBusy, oReady}), 32'b1110);
    checkOutput("load_bval", 32'(oBVal), 32'(b));
    if (keep) sb.push_back(golden(a, b));
  endtask

  task automatic waitResult(input string tag, input int hold, output int lat);
    int n = 0;
    int exp;
    while (!oValid && n < 400) begin
      @(posedge iClk); #1;
      n++;
    end
    lat = n + 1;
    checkOutput({tag, "_valid_seen"}, 32'(oValid), 32'd1);
    if (sb.size() == 0) begin
      checkOutput({tag, "_sb_nonempty"}, 32'd0, 32'd1);
      return;
    end
    exp = sb.pop_front();
    for (int i = 0; i < hold; i++) begin
      @(posedge iClk); #1;
      checkOutput({tag, "_hold_valid"}, 32'(oValid), 32'd1);
      checkOutput({tag, "_hold_result"}, 32'(oResult), 32'(exp));
    end
    checkOutput({tag, "_result"}, 32'(oResult), 32'(exp));
    iReady = 1'b1;
    @(posedge iClk); #1;
    iReady = 1'b0;
    checkOutput({tag, "_after_handshake"}, 32'({oValid, oReady}), 32'b01);
  endtask

  initial begin
    int lat;
    bit seenValid;
    iRstN  = 1'b0;
    iValid = 1'b0;
    iA     = '0;
    iB     = '0;
    iAbort = 1'b0;
    iReady = 1'b0;
    repeat (2) @(posedge iClk);
    #1;
    checkOutput("rst_ready", 32'(oReady), 32'd1);
    checkOutput("rst_ctrl", 32'({oBusy, oA, oLoadB, oClr, oValid}), 32'd0);
    checkOutput("rst_data", 32'({oBVal, oResult}), 32'd0);
    iRstN = 1'b1;
    @(posedge iClk); #1;

    $display("[TB] job A=0 B=255");
    applyStimulus(0, 255, 1'b1);
    waitResult("a0b255", 0, lat);
    checkOutput("a0b255_latency", 32'(lat), 32'(WINDOW + 2));
    checkOutput("a0b255_aones", 32'(aOnes), 32'd0);

    $display("[TB] job A=255 B=0");
    applyStimulus(255, 0, 1'b1);
    waitResult("a255b0", 0, lat);
    checkOutput("a255b0_aones", 32'(aOnes), 32'd255);

    $display("[TB] job A=255 B=255 with delayed ready");
    applyStimulus(255, 255, 1'b1);
    waitResult("a255b255", 5, lat);
    checkOutput("a255b255_aones", 32'(aOnes), 32'd255);

    $display("[TB] job A=128 B=128 then back-to-back job");
    applyStimulus(128, 128, 1'b1);
    waitResult("a128b128", 0, lat);
    applyStimulus(200, 100, 1'b1);
    waitResult("a200b100", 0, lat);
    checkOutput("a200b100_latency", 32'(lat), 32'(WINDOW + 2));

    $display("[TB] abort at RUN cycle 40");
    applyStimulus(200, 200, 1'b0);
    repeat (41) @(posedge iClk);
    #1;
    iAbort = 1'b1;
    #1;
    checkOutput("abort_oa_low", 32'(oA), 32'd0);
    @(posedge iClk); #1;
    iAbort = 1'b0;
    checkOutput("abort_clr_state", 32'({oClr, oReady, oBusy, oLoadB}), 32'b1000);
    @(posedge iClk); #1;
    checkOutput("abort_idle", 32'({oClr, oReady, oBusy}), 32'b010);
    seenValid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (oValid) seenValid = 1'b1;
      @(posedge iClk); #1;
    end
    checkOutput("abort_no_valid", 32'(seenValid), 32'd0);
    applyStimulus(100, 200, 1'b1);
    waitResult("post_abort", 0, lat);

    $display("[TB] reset at RUN cycle 100");
    applyStimulus(150, 90, 1'b0);
    repeat (101) @(posedge iClk);
    #2;
    iRstN = 1'b0;
    #1;
    checkOutput("midrst_ready", 32'(oReady), 32'd1);
    checkOutput("midrst_ctrl", 32'({oBusy, oA, oLoadB, oClr, oValid}), 32'd0);
    checkOutput("midrst_data", 32'({oBVal, oResult}), 32'd0);
    @(posedge iClk); #1;
    iRstN = 1'b1;
    @(posedge iClk); #1;
    applyStimulus(77, 180, 1'b1);
    waitResult("post_reset", 0, lat);
    checkOutput("post_reset_latency", 32'(lat), 32'(WINDOW + 2));
    checkOutput("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
